// File: rtl/iob_fifo_t2p_ctrl_if.sv
// Producer, consumer and two-port RAM signals of the FIFO controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface iob_fifo_t2p_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              w_en_i;
    logic [DATA_W-1:0] w_data_i;
    logic              w_full_o;
    logic              w_ovf_o;
    logic              r_en_i;
    logic [DATA_W-1:0] r_data_o;
    logic              r_valid_o;
    logic              r_empty_o;
    logic              r_unf_o;
    logic [ADDR_W:0]   level_o;
    logic              ext_mem_w_en_o;
    logic [ADDR_W-1:0] ext_mem_w_addr_o;
    logic [DATA_W-1:0] ext_mem_w_data_o;
    logic              ext_mem_r_en_o;
    logic [ADDR_W-1:0] ext_mem_r_addr_o;
    logic [DATA_W-1:0] ext_mem_r_data_i;

    modport slave (
        input  w_en_i, w_data_i, r_en_i, ext_mem_r_data_i,
        output w_full_o, w_ovf_o, r_data_o, r_valid_o, r_empty_o, r_unf_o, level_o,
               ext_mem_w_en_o, ext_mem_w_addr_o, ext_mem_w_data_o,
               ext_mem_r_en_o, ext_mem_r_addr_o
    );

    modport master (
        output w_en_i, w_data_i, r_en_i, ext_mem_r_data_i,
        input  w_full_o, w_ovf_o, r_data_o, r_valid_o, r_empty_o, r_unf_o, level_o,
               ext_mem_w_en_o, ext_mem_w_addr_o, ext_mem_w_data_o,
               ext_mem_r_en_o, ext_mem_r_addr_o
    );
endinterface

// File: rtl/iob_fifo_t2p_ctrl.sv
// Single-clock FIFO controller around an external two-port RAM with a
// registered read port; full/empty are told apart by the level counter.
module iob_fifo_t2p_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                rst_i,
    iob_fifo_t2p_ctrl_if.slave  fifo
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   level;
    logic              r_valid;
    logic              w_ovf;
    logic              r_unf;
    logic              w_full;
    logic              r_empty;
    logic              w_acc;
    logic              r_acc;
    logic [ADDR_W:0]   level_nxt;

    assign w_full  = (level == DEPTH);
    assign r_empty = (level == '0);

    // Accept decisions use only the registered status, so a write at full is
    // dropped even when a read frees a slot in the same cycle (and vice versa).
    assign w_acc = fifo.w_en_i & ~w_full  & ~rst_i;
    assign r_acc = fifo.r_en_i & ~r_empty & ~rst_i;

    always_comb begin
        level_nxt = level;
        unique case ({w_acc, r_acc})
            2'b10:   level_nxt = level + (ADDR_W+1)'(1);
            2'b01:   level_nxt = level - (ADDR_W+1)'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            r_valid <= 1'b0;
            w_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (rst_i) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            r_valid <= 1'b0;
            w_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_acc) wptr <= wptr + ADDR_W'(1);
            if (r_acc) rptr <= rptr + ADDR_W'(1);
            level   <= level_nxt;
            r_valid <= r_acc;
            w_ovf   <= fifo.w_en_i & w_full;
            r_unf   <= fifo.r_en_i & r_empty;
        end
    end

    assign fifo.ext_mem_w_en_o   = w_acc;
    assign fifo.ext_mem_w_addr_o = wptr;
    assign fifo.ext_mem_w_data_o = fifo.w_data_i;
    assign fifo.ext_mem_r_en_o   = r_acc;
    assign fifo.ext_mem_r_addr_o = rptr;

    // RAM read port is already registered, so data passes straight through.
    assign fifo.r_data_o  = fifo.ext_mem_r_data_i;
    assign fifo.r_valid_o = r_valid;
    assign fifo.w_full_o  = w_full;
    assign fifo.r_empty_o = r_empty;
    assign fifo.r_unf_o   = r_unf;
    assign fifo.w_ovf_o   = w_ovf;
    assign fifo.level_o   = level;
endmodule

// File: doc/iob_fifo_t2p_ctrl.md
# iob_fifo_t2p_ctrl

Synchronous FIFO controller that drives an external true two-port RAM (one write port, one registered read port) and turns it into a single-clock first-in/first-out buffer. It sits directly upstream of the two-port RAM. It generates the RAM write and read enables and addresses, consumes the RAM's one-cycle-latency read data, and presents flow-control status (full, empty, level) to producer and consumer logic.

## Interface
- DATA_W, 32, width of each FIFO word and of the RAM data ports
- ADDR_W, 4, RAM address width; FIFO depth is 2**ADDR_W words (ADDR_W >= 1)

- clk_i  input  1  clock; all state updates on rising edge
- arst_n_i  input  1  asynchronous active-low reset
- rst_i  input  1  synchronous clear, active-high; empties the FIFO
- w_en_i  input  1  producer write request
- w_data_i  input  DATA_W  producer write data
- w_full_o  output  1  FIFO full; writes are ignored
- w_ovf_o  output  1  one-cycle pulse: write requested while full
- r_en_i  input  1  consumer read request
- r_data_o  output  DATA_W  read data, valid while r_valid_o is high
- r_valid_o  output  1  read data valid, one cycle after an accepted read
- r_empty_o  output  1  FIFO empty; reads are ignored
- r_unf_o  output  1  one-cycle pulse: read requested while empty
- level_o  output  ADDR_W+1  number of stored words, 0..2**ADDR_W
- ext_mem_w_en_o  output  1  RAM write enable
- ext_mem_w_addr_o  output  ADDR_W  RAM write address
- ext_mem_w_data_o  output  DATA_W  RAM write data
- ext_mem_r_en_o  output  1  RAM read enable
- ext_mem_r_addr_o  output  ADDR_W  RAM read address
- ext_mem_r_data_i  input  DATA_W  RAM registered read data

## Operation
- State: write pointer wptr[ADDR_W-1:0], read pointer rptr[ADDR_W-1:0], level[ADDR_W:0], r_valid register.
- Write accepted: w_acc = w_en_i & ~w_full_o & ~rst_i.
- Read accepted: r_acc = r_en_i & ~r_empty_o & ~rst_i.
- Accept decisions use the registered status at the start of the cycle.
  - A write while full is dropped, even if a read is accepted in the same cycle.
  - A read while empty is dropped, even if a write is accepted in the same cycle.
- RAM drive is combinational:
  - ext_mem_w_en_o = w_acc, ext_mem_w_addr_o = wptr, ext_mem_w_data_o = w_data_i
  - ext_mem_r_en_o = r_acc, ext_mem_r_addr_o = rptr
- Pointer update: on w_acc, wptr <= wptr+1; on r_acc, rptr <= rptr+1. Both wrap modulo 2**ADDR_W with no extra wrap bit; full and empty are distinguished by level.
- Level update: level <= level + w_acc - r_acc. A simultaneous accepted read and write leaves level unchanged.
- Status:
  - w_full_o = (level == 2**ADDR_W)
  - r_empty_o = (level == 0)
  - level_o = level
- Read data:
  - r_valid_o <= r_acc.
  - r_data_o = ext_mem_r_data_i, passed through with no extra register.
  - r_data_o is don't-care when r_valid_o is low.
- Error pulses: w_ovf_o <= w_en_i & w_full_o & ~rst_i; r_unf_o <= r_en_i & r_empty_o & ~rst_i. Both are registered and last one cycle per offending request.
- Synchronous clear (rst_i=1): on that edge, pointers, level, r_valid_o, w_ovf_o and r_unf_o go to 0. Requests in that cycle are not accepted. RAM contents are not cleared.
- Read-after-write hazard: none. A word becomes readable only after its level increment, one cycle after its RAM write edge, so the RAM always returns the stored word.

## Timing
- Reset (arst_n_i low, asynchronous, any time): wptr=0, rptr=0, level_o=0, r_empty_o=1, w_full_o=0, r_valid_o=0, w_ovf_o=0, r_unf_o=0. Asserting reset mid-operation discards all content and any in-flight read (r_valid_o drops immediately).
- Write latency: a word written at edge N is visible in level_o and r_empty_o after edge N, so it can be read in cycle N+1.
- Read latency: r_en_i accepted in cycle N gives r_valid_o=1 and data in cycle N+1, after edge N.
- Back-to-back reads each cycle give one word per cycle. Throughput is one write plus one read per cycle.
- Full boundary:
  - At level 2**ADDR_W-1, a write with no read makes w_full_o high after the edge.
  - A write plus a read at full is a read only; level drops to 2**ADDR_W-1.
- Empty boundary: at level 1, a read with no write makes r_empty_o high after the edge.
- Wrap-around: pointers go from 2**ADDR_W-1 to 0 with no gap or stall.

## Test plan
- Reset then idle (ADDR_W=4): r_empty_o=1, w_full_o=0, level_o=0, r_valid_o=0; assert arst_n_i low mid-stream -> same values immediately.
- Write 0x00..0x0F in 16 consecutive cycles -> w_full_o=1 and level_o=16 after the 16th edge. A 17th write of 0xAA -> w_ovf_o pulses once, ext_mem_w_en_o=0, level_o stays 16.
- Drain the full FIFO with r_en_i held for 16 cycles -> r_valid_o high for 16 cycles, r_data_o=0x00..0x0F in order. r_empty_o=1 after the last accept. An extra read -> r_unf_o pulse, no r_valid_o.
- Write at level 0 plus a read in the same cycle -> only the write is accepted, level_o=1, r_unf_o=1. In the next cycle, write plus read -> level_o stays 1, r_valid_o=1 one cycle later.
- Wrap-around: 40 words 0x100+i through a continuous simultaneous write/read stream at level 3 -> output sequence in order with no loss; pointers wrap twice.
- rst_i pulse at level 7 together with w_en_i and r_en_i -> level_o=0, r_empty_o=1, no RAM write, r_valid_o=0 next cycle.
